// File: rtl/byte_stream_pkg.sv
// Shared definitions for the byte stream packer: byte width, the byte-order
// enum, and the helper that maps a byte index to its lane.
package byte_stream_pkg;

   localparam int BYTE_WIDTH = 8;

   typedef enum logic {
      ORDER_LE = 1'b0,
      ORDER_BE = 1'b1
   } order_e;

   // Little-endian fills lanes upward from lane 0; big-endian fills downward
   // from the top lane, so the first byte lands in the most significant lane.
   function automatic int unsigned lane_of(input int unsigned cnt,
                                           input order_e      ord,
                                           input int unsigned n);
      return (ord == ORDER_BE) ? (n - 1 - cnt) : cnt;
   endfunction

endpackage

// File: rtl/byte_stream_packer_lane_decoder.sv
// byte_lane_decoder: turns the current byte index and byte order into a
// one-hot lane enable, used both to steer the incoming byte into the
// assembly register and to build the lane-valid mask.
module byte_lane_decoder
   import byte_stream_pkg::*;
#(
   parameter int N  = 4,
   parameter int CW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [CW-1:0] cnt,
   input  order_e        ord,
   output logic [N-1:0]  lane_en
);

   // Each lane compares its own index against the mapped lane number.
   for (genvar j = 0; j < N; j++) begin : g_lane
      assign lane_en[j] = (lane_of(32'(cnt), ord, N) == j);
   end

endmodule

// File: rtl/byte_stream_packer.sv
// byte_stream_packer: accepts one byte per cycle and assembles DATA_WIDTH-bit
// words, with the byte order chosen per word from big_endian_i.
// Optional feature macro: BYTE_STREAM_PACKER_KEEP_EN adds the m_keep_o
// lane-valid mask; without it partial words are only zero-filled and flagged
// by m_last_o.
module byte_stream_packer
   import byte_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    s_rst_n_i,
   input  logic                    big_endian_i,
   input  logic [7:0]              s_data_i,
   input  logic                    s_valid_i,
   input  logic                    s_last_i,
   output logic                    s_ready_o,
   output logic [DATA_WIDTH-1:0]   m_data_o,
   output logic                    m_valid_o,
   output logic                    m_last_o,
`ifdef BYTE_STREAM_PACKER_KEEP_EN
   output logic [DATA_WIDTH/8-1:0] m_keep_o,
`endif
   input  logic                    m_ready_i
);

   localparam int N  = DATA_WIDTH / BYTE_WIDTH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (((DATA_WIDTH % BYTE_WIDTH) != 0) || (DATA_WIDTH < 16)) begin : g_bad_width
      $error("byte_stream_packer: DATA_WIDTH must be a multiple of 8 and at least 16");
   end

   logic [CW-1:0]         cnt;
   order_e                ord;
   order_e                cur_ord;
   logic [DATA_WIDTH-1:0] asm_q;
   logic [DATA_WIDTH-1:0] merged;
   logic [N-1:0]          lane_en;
   logic                  accept;
   logic                  complete;

   // The output register is free when empty or emptying this cycle, so a new
   // word can replace a draining one without a bubble.
   assign s_ready_o = !m_valid_o || m_ready_i;
   assign accept    = s_valid_i && s_ready_o;
   assign complete  = accept && ((cnt == CW'(N - 1)) || s_last_i);

   // The order of a word is taken from the pin on its first byte and then
   // held, so mid-word changes of big_endian_i have no effect.
   assign cur_ord = (cnt == '0) ? order_e'(big_endian_i) : ord;

   byte_lane_decoder #(
      .N  (N),
      .CW (CW)
   ) u_lane_decoder (
      .cnt     (cnt),
      .ord     (cur_ord),
      .lane_en (lane_en)
   );

   // Partial word with the incoming byte dropped into its lane.
   always_comb begin
      merged = asm_q;
      for (int j = 0; j < N; j++) begin
         if (lane_en[j]) begin
            merged[j*BYTE_WIDTH +: BYTE_WIDTH] = s_data_i;
         end
      end
   end

   // Assembly state: byte counter, latched order and partial word; cleared
   // whenever a word completes so unfilled lanes of the next word read zero.
   always_ff @(posedge clk_i) begin
      if (!s_rst_n_i) begin
         cnt   <= '0;
         ord   <= ORDER_LE;
         asm_q <= '0;
      end else if (accept) begin
         if (cnt == '0) begin
            ord <= cur_ord;
         end
         if (complete) begin
            cnt   <= '0;
            asm_q <= '0;
         end else begin
            cnt   <= cnt + CW'(1);
            asm_q <= merged;
         end
      end
   end

`ifdef BYTE_STREAM_PACKER_KEEP_EN
   logic [N-1:0] asm_keep;

   // Lane-valid mask for the word under assembly and for the output word.
   always_ff @(posedge clk_i) begin
      if (!s_rst_n_i) begin
         asm_keep <= '0;
         m_keep_o <= '0;
      end else if (accept) begin
         if (complete) begin
            asm_keep <= '0;
            m_keep_o <= asm_keep | lane_en;
         end else begin
            asm_keep <= asm_keep | lane_en;
         end
      end
   end
`endif

   // Output register: loads on a completing byte, otherwise holds until the
   // downstream handshake empties it.
   always_ff @(posedge clk_i) begin
      if (!s_rst_n_i) begin
         m_data_o  <= '0;
         m_last_o  <= 1'b0;
         m_valid_o <= 1'b0;
      end else if (complete) begin
         m_data_o  <= merged;
         m_last_o  <= s_last_i;
         m_valid_o <= 1'b1;
      end else if (m_valid_o && m_ready_i) begin
         m_valid_o <= 1'b0;
      end
   end

endmodule
